// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// The optional performance counters are sized by CNT_W.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_IO  = 1'b1
  } owner_t;

  localparam int CNT_W = 16;

  // Saturating increment used by the optional performance counters.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational round-robin picker for the cpu and io requesters.
// On a tie the requester that did not own the RAM last time wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   io_req,
  input  owner_t last_owner,
  output logic   valid,
  output owner_t winner
);

  always_comb begin
    valid  = cpu_req | io_req;
    winner = OWN_CPU;
    if (cpu_req && io_req) begin
      winner = (last_owner == OWN_CPU) ? OWN_IO : OWN_CPU;
    end else if (io_req) begin
      winner = OWN_IO;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data RAM between the cpu data path and the io port.
// Define MEM_ARB_PERF_EN to add saturating transaction and conflict counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_done,
  output logic [DATA_W-1:0] io_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  cpu_cnt,
  output logic [CNT_W-1:0]  io_cnt,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  localparam logic [1:0] StIdle   = IDLE;
  localparam logic [1:0] StAccess = ACCESS;
  localparam logic [1:0] StWait   = WAIT;
  localparam logic [1:0] StDone   = DONE;

  // WAIT runs RD_LAT cycles after ACCESS so the capture lines up with mem_rdata.
  localparam logic [2:0] LatInit = 3'(RD_LAT - 1);

  logic [1:0]        state;
  owner_t            owner;
  owner_t            lastOwner;
  logic              capWe;
  logic [ADDR_W-1:0] capAddr;
  logic [DATA_W-1:0] capWdata;
  logic [2:0]        latCnt;
  logic              arbValid;
  owner_t            arbWinner;
  logic              inAccess;
  logic              inDone;

  mem_arb_rr uRr (
    .cpu_req    (cpu_req),
    .io_req     (io_req),
    .last_owner (lastOwner),
    .valid      (arbValid),
    .winner     (arbWinner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      owner     <= OWN_CPU;
      lastOwner <= OWN_IO;
      capWe     <= 1'b0;
      capAddr   <= '0;
      capWdata  <= '0;
      latCnt    <= '0;
      cpu_rdata <= '0;
      io_rdata  <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (arbValid) begin
            owner     <= arbWinner;
            lastOwner <= arbWinner;
            if (arbWinner == OWN_CPU) begin
              capWe    <= cpu_we;
              capAddr  <= cpu_addr;
              capWdata <= cpu_wdata;
            end else begin
              capWe    <= io_we;
              capAddr  <= io_addr;
              capWdata <= io_wdata;
            end
            state <= StAccess;
          end
        end
        StAccess: begin
          if (capWe) begin
            state <= StDone;
          end else begin
            latCnt <= LatInit;
            state  <= StWait;
          end
        end
        StWait: begin
          if (latCnt == 3'd0) begin
            if (owner == OWN_CPU) begin
              cpu_rdata <= mem_rdata;
            end else begin
              io_rdata <= mem_rdata;
            end
            state <= StDone;
          end else begin
            latCnt <= latCnt - 3'd1;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign inAccess  = (state == StAccess);
  assign inDone    = (state == StDone);
  assign busy      = (state != StIdle);
  assign cpu_gnt   = busy && (owner == OWN_CPU);
  assign io_gnt    = busy && (owner == OWN_IO);
  assign cpu_done  = inDone && (owner == OWN_CPU);
  assign io_done   = inDone && (owner == OWN_IO);
  assign mem_en    = inAccess;
  assign mem_we    = inAccess && capWe;
  assign mem_addr  = inAccess ? capAddr : '0;
  assign mem_wdata = inAccess ? capWdata : '0;

`ifdef MEM_ARB_PERF_EN
  // Completions count in DONE; conflicts count only when a tie is arbitrated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_cnt      <= '0;
      io_cnt       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (cpu_done) begin
        cpu_cnt <= satInc(cpu_cnt);
      end
      if (io_done) begin
        io_cnt <= satInc(io_cnt);
      end
      if ((state == StIdle) && cpu_req && io_req) begin
        conflict_cnt <= satInc(conflict_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small read-only RAM model.
// With MEM_ARB_PERF_EN defined the performance counters are checked as well.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_gnt, cpu_done;
  logic [31:0] cpu_rdata;
  logic        io_req = 1'b0, io_we = 1'b0;
  logic [7:0]  io_addr = '0;
  logic [31:0] io_wdata = '0;
  logic        io_gnt, io_done;
  logic [31:0] io_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;
`ifdef MEM_ARB_PERF_EN
  logic [15:0] cpu_cnt, io_cnt, conflict_cnt;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [256];
  logic [31:0] rdPipe = '0;

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .io_req    (io_req),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_gnt    (io_gnt),
    .io_done   (io_done),
    .io_rdata  (io_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
`ifdef MEM_ARB_PERF_EN
    ,
    .cpu_cnt      (cpu_cnt),
    .io_cnt       (io_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Two-stage read pipeline: data for the address seen in cycle N is valid in N+2.
  always @(posedge clk) begin
    rdPipe    <= ram[mem_addr];
    mem_rdata <= rdPipe;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [7:0] cAddr,
                               input logic [31:0] cData, input logic iReq, input logic iWe,
                               input logic [7:0] iAddr, input logic [31:0] iData);
    cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cData;
    io_req  = iReq; io_we  = iWe; io_addr  = iAddr; io_wdata  = iData;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();
  endtask

  task automatic waitDone(input bit isCpu, input string tag);
    int n = 0;
    while (!(isCpu ? cpu_done : io_done) && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput(tag, {31'd0, (isCpu ? cpu_done : io_done)}, 32'd1);
  endtask

  initial begin
    int doneSeen;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h20] = 32'h12345678;
    ram[8'h30] = 32'hA5A5A5A5;
    ram[8'h40] = 32'hCAFEF00D;

    #3;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mem_en", {31'd0, mem_en}, 32'd0);
    checkOutput("rst_gnt", {30'd0, cpu_gnt, io_gnt}, 32'd0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 32'h0);
    doReset();

    // Single cpu write.
    applyStimulus(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0);
    checkOutput("wr_c0_busy", {31'd0, busy}, 32'd0);
    nextCycle();
    checkOutput("wr_c1_en_we", {30'd0, mem_en, mem_we}, 32'd3);
    checkOutput("wr_c1_addr", {24'd0, mem_addr}, 32'h10);
    checkOutput("wr_c1_wdata", mem_wdata, 32'hDEADBEEF);
    checkOutput("wr_c1_busy_gnt", {30'd0, busy, cpu_gnt}, 32'd3);
    checkOutput("wr_c1_done", {31'd0, cpu_done}, 32'd0);
    nextCycle();
    checkOutput("wr_c2_done", {31'd0, cpu_done}, 32'd1);
    checkOutput("wr_c2_busy_en", {30'd0, busy, mem_en}, 32'd2);
    cpu_req = 1'b0;
    nextCycle();
    checkOutput("wr_c3_idle", {29'd0, busy, cpu_done, cpu_gnt}, 32'd0);

    // Single io read, RD_LAT = 2.
    applyStimulus(0, 0, 8'h00, 32'h0, 1, 0, 8'h20, 32'h0);
    nextCycle();
    checkOutput("rd_c1_en_we", {30'd0, mem_en, mem_we}, 32'd2);
    checkOutput("rd_c1_addr", {24'd0, mem_addr}, 32'h20);
    checkOutput("rd_c1_io_gnt", {31'd0, io_gnt}, 32'd1);
    nextCycle();
    checkOutput("rd_c2_done", {31'd0, io_done}, 32'd0);
    nextCycle();
    checkOutput("rd_c3_done", {31'd0, io_done}, 32'd0);
    nextCycle();
    checkOutput("rd_c4_done", {31'd0, io_done}, 32'd1);
    checkOutput("rd_c4_rdata", io_rdata, 32'h12345678);
    io_req = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("rd_hold_rdata", io_rdata, 32'h12345678);
    checkOutput("rd_cpu_rdata_untouched", cpu_rdata, 32'h0);

    // cpu read with request dropped during WAIT.
    applyStimulus(1, 0, 8'h40, 32'h0, 0, 0, 8'h00, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("drop_c2_busy", {31'd0, busy}, 32'd1);
    cpu_req = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("drop_c4_done", {31'd0, cpu_done}, 32'd1);
    checkOutput("drop_c4_rdata", cpu_rdata, 32'hCAFEF00D);
    checkOutput("drop_io_rdata_held", io_rdata, 32'h12345678);
    nextCycle();
    checkOutput("drop_c5_idle", {31'd0, busy}, 32'd0);

    // Reset asserted mid-WAIT.
    applyStimulus(1, 0, 8'h30, 32'h0, 0, 0, 8'h00, 32'h0);
    nextCycle();
    nextCycle();
    checkOutput("rstw_in_wait", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    checkOutput("rstw_busy_gnt_en", {29'd0, busy, cpu_gnt, mem_en}, 32'd0);
    checkOutput("rstw_rdata", cpu_rdata, 32'h0);
    checkOutput("rstw_io_rdata", io_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      if (cpu_done || busy) doneSeen++;
    end
    checkOutput("rstw_no_done", doneSeen, 32'd0);

    // Simultaneous requests held high: cpu, io, cpu, io.
    doReset();
    applyStimulus(1, 1, 8'h01, 32'h11, 1, 1, 8'h02, 32'h22);
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      checkOutput($sformatf("rr%0d_gnt", k), {30'd0, cpu_gnt, io_gnt}, (k % 2 == 0) ? 32'd2 : 32'd1);
      checkOutput($sformatf("rr%0d_addr", k), {24'd0, mem_addr}, (k % 2 == 0) ? 32'h01 : 32'h02);
      nextCycle();
      checkOutput($sformatf("rr%0d_done", k), {30'd0, cpu_done, io_done}, (k % 2 == 0) ? 32'd2 : 32'd1);
      if (k == 3) applyStimulus(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
      nextCycle();
    end
    checkOutput("rr_end_idle", {31'd0, busy}, 32'd0);

`ifdef MEM_ARB_PERF_EN
    // One conflict, then singles: 3 cpu and 2 io completions in total.
    doReset();
    applyStimulus(1, 1, 8'h05, 32'h5, 1, 1, 8'h06, 32'h6);
    waitDone(1'b1, "perf_conf_cpu_done");
    cpu_req = 1'b0;
    nextCycle();
    waitDone(1'b0, "perf_conf_io_done");
    io_req = 1'b0;
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 8'h07, 32'h7, 0, 0, 8'h00, 32'h0);
      nextCycle();
      waitDone(1'b1, "perf_cpu_done");
      cpu_req = 1'b0;
      nextCycle();
    end
    applyStimulus(0, 0, 8'h00, 32'h0, 1, 1, 8'h08, 32'h8);
    nextCycle();
    waitDone(1'b0, "perf_io_done");
    io_req = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("perf_cpu_cnt", {16'd0, cpu_cnt}, 32'd3);
    checkOutput("perf_io_cnt", {16'd0, io_cnt}, 32'd2);
    checkOutput("perf_conflict_cnt", {16'd0, conflict_cnt}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
